iq_alloc: RTL

Issue-queue entry allocator, directly upstream of the 16-entry centralized issue queue. Tracks which issue-queue entries are free and assigns up to DECODE_NUM free entry addresses per cycle to renamed instructions. Reclaims entries granted by the select arbiter and tags each allocated instruction with a wrapping age. Stalls dispatch atomically when the requested group does not fit.

---
 rtl/iq_alloc_if.sv | 29 ++
 rtl/iq_alloc.sv | 90 +++++++++
 2 files changed

// File: rtl/iq_alloc_if.sv
// Dispatch/arbiter-facing bundle of the issue-queue allocator.
// The allocator connects through the slave modport and its driver through the master modport.
interface iq_alloc_if #(
   parameter int DECODE_NUM = 4,
   parameter int ISSUE_NUM  = 4,
   parameter int CIQ_DEPTH  = 16,
   parameter int ADDR_W     = 4,
   parameter int AGE        = 5
);
   logic [DECODE_NUM-1:0]             dispatch_valid;
   logic [ISSUE_NUM-1:0][ADDR_W-1:0]  arbit_addr;
   logic [ISSUE_NUM-1:0]              arbit_grant;
   logic                              flush;
   logic [DECODE_NUM-1:0][ADDR_W-1:0] free_addr;
   logic [DECODE_NUM-1:0]             free_valid;
   logic [DECODE_NUM-1:0][AGE-1:0]    age_out;
   logic                              dispatch_stall;
   logic [ADDR_W:0]                   free_count;

   modport master (
      output dispatch_valid, arbit_addr, arbit_grant, flush,
      input  free_addr, free_valid, age_out, dispatch_stall, free_count
   );

   modport slave (
      input  dispatch_valid, arbit_addr, arbit_grant, flush,
      output free_addr, free_valid, age_out, dispatch_stall, free_count
   );
endinterface

// File: rtl/iq_alloc.sv
// Issue-queue entry allocator: hands out the lowest free entries to a dispatch group
// all-or-nothing, reclaims entries on arbiter grants, and tags each allocation with a wrapping age.
module iq_alloc #(
   parameter int DECODE_NUM = 4,
   parameter int ISSUE_NUM  = 4,
   parameter int CIQ_DEPTH  = 16,
   parameter int ADDR_W     = 4,
   parameter int AGE        = 5
) (
   input logic        clk,
   input logic        rst_n,
   iq_alloc_if.slave  bus
);
   localparam int CW = ADDR_W + 1;

   logic [CIQ_DEPTH-1:0] free_map;
   logic [CIQ_DEPTH-1:0] avail;
   logic [CIQ_DEPTH-1:0] alloc_mask;
   logic [CIQ_DEPTH-1:0] release_mask;
   logic [CIQ_DEPTH-1:0] next_map;
   logic [AGE-1:0]       age_ctr;
   logic [AGE-1:0]       n_alloc;
   logic [CW-1:0]        free_count_q;
   logic [ADDR_W-1:0]    pick;
   logic                 found;
   logic                 do_alloc;
   int                   n_req;
   int                   n_free;

   // Slots are served in index order; each takes the lowest entry not already claimed this cycle.
   always_comb begin
      n_req              = $countones(bus.dispatch_valid);
      n_free             = $countones(free_map);
      do_alloc           = !bus.flush && (n_req <= n_free);
      bus.dispatch_stall = !bus.flush && (n_req > n_free);
      avail              = free_map;
      alloc_mask         = '0;
      n_alloc            = '0;
      pick               = '0;
      found              = 1'b0;
      bus.free_addr      = '0;
      bus.free_valid     = '0;
      bus.age_out        = '0;
      for (int i = 0; i < DECODE_NUM; i++) begin
         if (do_alloc && bus.dispatch_valid[i]) begin
            pick  = '0;
            found = 1'b0;
            for (int e = 0; e < CIQ_DEPTH; e++) begin
               if (!found && avail[e]) begin
                  found = 1'b1;
                  pick  = ADDR_W'(e);
               end
            end
            avail[pick]       = 1'b0;
            alloc_mask[pick]  = 1'b1;
            bus.free_addr[i]  = pick;
            bus.free_valid[i] = 1'b1;
            bus.age_out[i]    = age_ctr + n_alloc;
            n_alloc           = n_alloc + AGE'(1);
         end
      end
   end

   // Released entries are busy, so they never overlap alloc_mask; duplicates simply OR together.
   always_comb begin
      release_mask = '0;
      for (int j = 0; j < ISSUE_NUM; j++) begin
         if (bus.arbit_grant[j]) release_mask[bus.arbit_addr[j]] = 1'b1;
      end
      next_map = (free_map & ~alloc_mask) | release_mask;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         free_map     <= '1;
         age_ctr      <= '0;
         free_count_q <= CW'(CIQ_DEPTH);
      end else if (bus.flush) begin
         free_map     <= '1;
         age_ctr      <= '0;
         free_count_q <= CW'(CIQ_DEPTH);
      end else begin
         free_map     <= next_map;
         age_ctr      <= age_ctr + n_alloc;
         free_count_q <= CW'($countones(next_map));
      end
   end

   assign bus.free_count = free_count_q;
endmodule
